// File: rtl/tlc_pkg.sv
// tlc_pkg: shared definitions for the intersection phase scheduler.
//   colour_t : per-approach signal head colour (RED/YELLOW/GREEN)
//   state_t  : scheduler state (GRN/YEL/ARD)
//   TMR_W    : width of the phase timer
package tlc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colour_t;

  typedef enum logic [1:0] {
    GRN = 2'd0,
    YEL = 2'd1,
    ARD = 2'd2
  } state_t;

  localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick: combinational round-robin picker.
//   req        in  N_PHASES   per-approach service requests
//   cur_phase  in  clog2(N)   phase holding right-of-way (excluded from search)
//   next_phase out clog2(N)   first requesting phase after cur_phase, wrapping
//   valid      out 1          some phase other than cur_phase is requesting
module tlc_rr_pick #(
  parameter int unsigned N_PHASES = 4
) (
  input  logic [N_PHASES-1:0]         req,
  input  logic [$clog2(N_PHASES)-1:0] cur_phase,
  output logic [$clog2(N_PHASES)-1:0] next_phase,
  output logic                        valid
);

  localparam int unsigned PW = $clog2(N_PHASES);

  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    next_phase = cur_phase;
    valid      = 1'b0;
    idx        = '0;
    for (int unsigned k = N_PHASES - 1; k >= 1; k--) begin
      idx = PW'((32'(cur_phase) + k) % N_PHASES);
      if (req[idx]) begin
        next_phase = idx;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: actuated round-robin scheduler sharing one right-of-way
// among N_PHASES approaches (green -> yellow -> all-red -> next green).
//   clock          in  1           system clock, rising edge
//   clear_n        in  1           asynchronous active-low reset
//   req            in  N_PHASES    vehicle sensors, 1 = waiting
//   preempt        in  1           emergency preemption request
//   preempt_phase  in  clog2(N)    phase forced green under preemption
//   lights         out 2*N_PHASES  lights[2i+1:2i] = colour of phase i
//   cur_phase      out clog2(N)    phase holding right-of-way
//   grant          out N_PHASES    one-cycle pulse on first green cycle
// Optional feature: define TLC_PREEMPT_EN to enable emergency preemption;
// otherwise preempt/preempt_phase are ignored.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned N_PHASES   = 4,
  parameter int unsigned MIN_GRN    = 4,
  parameter int unsigned MAX_GRN    = 10,
  parameter int unsigned YEL_CYC    = 2,
  parameter int unsigned ALLRED_CYC = 1
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic [N_PHASES-1:0]         req,
  input  logic                        preempt,
  input  logic [$clog2(N_PHASES)-1:0] preempt_phase,
  output logic [2*N_PHASES-1:0]       lights,
  output logic [$clog2(N_PHASES)-1:0] cur_phase,
  output logic [N_PHASES-1:0]         grant
);

  localparam int unsigned PW = $clog2(N_PHASES);
  localparam logic [TMR_W-1:0] MIN_T = TMR_W'(MIN_GRN - 1);
  localparam logic [TMR_W-1:0] MAX_T = TMR_W'(MAX_GRN - 1);
  localparam logic [TMR_W-1:0] YEL_T = TMR_W'(YEL_CYC - 1);
  localparam logic [TMR_W-1:0] ARD_T = TMR_W'(ALLRED_CYC - 1);
  localparam logic [TMR_W-1:0] ONE   = TMR_W'(1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [PW-1:0]    next_phase;
  logic [PW-1:0]    pick;
  logic             other_req;
  logic             pre_act;
  logic [PW-1:0]    pre_phase;
  logic [PW-1:0]    serve;

  tlc_rr_pick #(.N_PHASES(N_PHASES)) u_pick (
    .req       (req),
    .cur_phase (cur_phase),
    .next_phase(pick),
    .valid     (other_req)
  );

`ifdef TLC_PREEMPT_EN
  assign pre_act   = preempt;
  assign pre_phase = (32'(preempt_phase) < N_PHASES) ? preempt_phase : '0;
`else
  logic unused_preempt;
  assign unused_preempt = ^{preempt, preempt_phase};
  assign pre_act        = 1'b0;
  assign pre_phase      = '0;
`endif

  // A preemption present on the last all-red cycle still decides who is served.
  assign serve = pre_act ? pre_phase : next_phase;

  function automatic logic [2*N_PHASES-1:0] show(input logic [PW-1:0] ph,
                                                  input colour_t c);
    logic [2*N_PHASES-1:0] v;
    v = '0;
    v[{ph, 1'b0} +: 2] = c;
    return v;
  endfunction

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state      <= GRN;
      cur_phase  <= '0;
      timer      <= '0;
      next_phase <= '0;
      grant      <= '0;
      lights     <= show('0, GREEN);
    end else begin
      grant <= '0;
      case (state)
        GRN: begin
          if (pre_act && (pre_phase != cur_phase)) begin
            state      <= YEL;
            timer      <= '0;
            next_phase <= pre_phase;
            lights     <= show(cur_phase, YELLOW);
          end else if (!pre_act && other_req && (timer >= MIN_T) &&
                       (!req[cur_phase] || (timer == MAX_T))) begin
            state      <= YEL;
            timer      <= '0;
            next_phase <= pick;
            lights     <= show(cur_phase, YELLOW);
          end else if (timer != MAX_T) begin
            // Saturating keeps max-out armed while resting or preempt-holding.
            timer <= timer + ONE;
          end
        end
        YEL: begin
          if (pre_act) next_phase <= pre_phase;
          if (timer == YEL_T) begin
            state  <= ARD;
            timer  <= '0;
            lights <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end
        ARD: begin
          if (pre_act) next_phase <= pre_phase;
          if (timer == ARD_T) begin
            state     <= GRN;
            timer     <= '0;
            cur_phase <= serve;
            grant     <= N_PHASES'(1) << serve;
            lights    <= show(serve, GREEN);
          end else begin
            timer <= timer + ONE;
          end
        end
        default: state <= GRN;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
`timescale 1ns/1ps
module tb_tlc_phase_scheduler;

  localparam int N    = 4;
  localparam int MIN  = 4;
  localparam int MAXG = 10;
  localparam int YELC = 2;
  localparam int ARDC = 1;
`ifdef TLC_PREEMPT_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic [3:0] req = '0;
  logic       preempt = 1'b0;
  logic [1:0] preempt_phase = '0;
  logic [7:0] lights;
  logic [1:0] cur_phase;
  logic [3:0] grant;

  int errors = 0;
  int checks = 0;

  // Reference model: colour 0 = green, 1 = yellow, 2 = all-red; age counts
  // cycles spent in the current colour without saturation.
  int m_phase, m_col, m_age, m_next, m_grant_ph;

  tlc_phase_scheduler #(
    .N_PHASES(4), .MIN_GRN(4), .MAX_GRN(10), .YEL_CYC(2), .ALLRED_CYC(1)
  ) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .req          (req),
    .preempt      (preempt),
    .preempt_phase(preempt_phase),
    .lights       (lights),
    .cur_phase    (cur_phase),
    .grant        (grant)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] m_lights();
    int code;
    code = (m_col == 0) ? 2 : (m_col == 1) ? 1 : 0;
    return 8'(code << (2 * m_phase));
  endfunction

  function automatic logic [1:0] m_cur();
    return 2'(m_phase);
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_grant_ph < 0) ? 4'b0 : 4'(1 << m_grant_ph);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_col = 0; m_age = 0; m_next = 0; m_grant_ph = -1;
  endtask

  task automatic model_step();
    bit pa;
    int pp;
    bit others;
    pa = PRE_EN && preempt;
    pp = int'(preempt_phase);
    if (pp >= N) pp = 0;
    m_grant_ph = -1;
    case (m_col)
      0: begin
        others = 0;
        for (int k = 0; k < N; k++) if (req[k] && k != m_phase) others = 1;
        if (pa && pp != m_phase) begin
          m_col = 1; m_age = 0; m_next = pp;
        end else if (!pa && others && m_age >= MIN - 1 &&
                     (!req[m_phase] || m_age >= MAXG - 1)) begin
          m_col = 1; m_age = 0; m_next = -1;
          for (int k = 1; k < N; k++)
            if (m_next < 0 && req[(m_phase + k) % N]) m_next = (m_phase + k) % N;
        end else m_age++;
      end
      1: begin
        if (pa) m_next = pp;
        if (m_age >= YELC - 1) begin m_col = 2; m_age = 0; end else m_age++;
      end
      default: begin
        if (pa) m_next = pp;
        if (m_age >= ARDC - 1) begin
          m_col = 0; m_age = 0; m_phase = m_next; m_grant_ph = m_next;
        end else m_age++;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  // Holds reset through one rising edge, releases on a falling edge.
  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req = '0; preempt = 1'b0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({lights, cur_phase, grant} !== {8'h02, 2'd0, 4'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got lights=%h ph=%0d grant=%b want 02/0/0000",
                 i, lights, cur_phase, grant);
      end
      tick();
    end
  endtask

  task automatic test_single_req();
    logic [7:0] exp_l [0:8];
    exp_l = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h20, 8'h20};
    req = 4'b0100;
    do_reset();
    for (int s = 0; s <= 8; s++) begin
      checks++;
      if (lights !== exp_l[s] || grant !== ((s == 7) ? 4'b0100 : 4'b0000) ||
          (s >= 7 && cur_phase !== 2'd2)) begin
        errors++;
        $display("FAIL single_req s=%0d got lights=%h grant=%b ph=%0d want lights=%h",
                 s, lights, grant, cur_phase, exp_l[s]);
      end
      tick();
    end
  endtask

  task automatic test_maxout();
    logic [7:0] exp_l [$];
    for (int i = 0; i < 10; i++) exp_l.push_back(8'h02);
    exp_l.push_back(8'h01); exp_l.push_back(8'h01); exp_l.push_back(8'h00);
    for (int i = 0; i < 10; i++) exp_l.push_back(8'h08);
    exp_l.push_back(8'h04); exp_l.push_back(8'h04); exp_l.push_back(8'h00);
    for (int i = 0; i < 4; i++) exp_l.push_back(8'h02);
    req = 4'b0011;
    do_reset();
    foreach (exp_l[s]) begin
      checks++;
      if (lights !== exp_l[s]) begin
        errors++;
        $display("FAIL maxout s=%0d got lights=%h want %h", s, lights, exp_l[s]);
      end
      checks++;
      if ({lights, cur_phase, grant} !== {m_lights(), m_cur(), m_grant()}) begin
        errors++;
        $display("FAIL maxout_model s=%0d got %h/%0d/%b want %h/%0d/%b", s,
                 lights, cur_phase, grant, m_lights(), m_cur(), m_grant());
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    bit found;
    int gq [$];
    req = 4'b0010;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (grant === 4'b0010) found = 1;
    end
    checks++;
    if (!found || cur_phase !== 2'd1 || lights !== 8'h08) begin
      errors++;
      $display("FAIL wrap_reach_ph1 got ph=%0d lights=%h want ph=1 lights=08",
               cur_phase, lights);
    end
    req = 4'b1001;
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int b = 0; b < N; b++) if (grant[b]) gq.push_back(b);
      checks++;
      if ({lights, cur_phase, grant} !== {m_lights(), m_cur(), m_grant()}) begin
        errors++;
        $display("FAIL wrap_model i=%0d got %h/%0d/%b want %h/%0d/%b", i,
                 lights, cur_phase, grant, m_lights(), m_cur(), m_grant());
      end
    end
    checks++;
    if (gq.size() < 2 || gq[0] != 3 || gq[1] != 0) begin
      errors++;
      $display("FAIL wrap_order got %0d grants first=%0d want order 3 then 0",
               gq.size(), (gq.size() > 0) ? gq[0] : -1);
    end
  endtask

  task automatic test_reset_in_yel();
    bit found;
    logic [7:0] exp_l [0:4];
    exp_l = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h01};
    req = 4'b0100;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (cur_phase === 2'd2) req = 4'b0001;
      if (lights === 8'h10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_yel_reach got lights=%h want 10", lights);
    end
    #2 clear_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({lights, cur_phase, grant} !== {8'h02, 2'd0, 4'b0}) begin
      errors++;
      $display("FAIL reset_async got %h/%0d/%b want 02/0/0000", lights, cur_phase, grant);
    end
    req = 4'b0100;
    @(negedge clock);
    clear_n = 1'b1;
    for (int s = 0; s <= 4; s++) begin
      checks++;
      if (lights !== exp_l[s]) begin
        errors++;
        $display("FAIL reset_min_green s=%0d got lights=%h want %h", s, lights, exp_l[s]);
      end
      tick();
    end
  endtask

  task automatic test_preempt();
    req = 4'b1111; preempt = 1'b0; preempt_phase = 2'd0;
    do_reset();
    tick();
    preempt = 1'b1; preempt_phase = 2'd3;
    for (int s = 2; s < 22; s++) begin
      tick();
      checks++;
      if (s == 2 && lights !== (PRE_EN ? 8'h01 : 8'h02)) begin
        errors++;
        $display("FAIL preempt_first got lights=%h want %h", lights, PRE_EN ? 8'h01 : 8'h02);
      end else if (PRE_EN && s >= 5 && lights !== 8'h80) begin
        errors++;
        $display("FAIL preempt_hold s=%0d got lights=%h want 80", s, lights);
      end else if ({lights, cur_phase, grant} !== {m_lights(), m_cur(), m_grant()}) begin
        errors++;
        $display("FAIL preempt_model s=%0d got %h/%0d/%b want %h/%0d/%b", s,
                 lights, cur_phase, grant, m_lights(), m_cur(), m_grant());
      end
    end
    preempt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({lights, cur_phase, grant} !== {m_lights(), m_cur(), m_grant()}) begin
        errors++;
        $display("FAIL preempt_release i=%0d got %h/%0d/%b want %h/%0d/%b", i,
                 lights, cur_phase, grant, m_lights(), m_cur(), m_grant());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        preempt = ~preempt;
        preempt_phase = 2'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        clear_n = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        model_reset();
      end
      tick();
      checks++;
      if ({lights, cur_phase, grant} !== {m_lights(), m_cur(), m_grant()}) begin
        errors++;
        $display("FAIL random i=%0d req=%b pre=%b/%0d got %h/%0d/%b want %h/%0d/%b", i,
                 req, preempt, preempt_phase, lights, cur_phase, grant,
                 m_lights(), m_cur(), m_grant());
      end
    end
    preempt = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_req();
    test_maxout();
    test_wrap();
    test_reset_in_yel();
    test_preempt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
